// File: rtl/full_adder.sv
// One-bit full adder: the shared arithmetic cell of the bit-serial datapath.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b ^ i_c;
    assign o_carry = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder consumes one LSB-first bit pair per cycle,
// with a registered carry loop and a valid/ready result port.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_sum;
    logic             w_carry;
    logic [WIDTH-1:0] w_res_next;

    full_adder u_fa (
        .i_a     (r_a[0]),
        .i_b     (r_b[0]),
        .i_c     (r_carry),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
    assign w_res_next = (r_res >> 1) | (WIDTH'(w_sum) << (WIDTH - 1));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum_out   <= '0;
            cout      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= a_in;
                        r_b      <= b_in;
                        r_carry  <= cin;
                        r_cnt    <= '0;
                        r_state  <= S_RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= w_carry;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    // Last bit: publish the completed word and final carry straight to the outputs.
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state   <= S_DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        sum_out   <= w_res_next;
                        cout      <= w_carry;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state   <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: scoreboard on the WIDTH=8 instance plus a WIDTH=1 corner instance.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clock = 1'b0;
    logic         resetn;
    logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [W-1:0] a_in, b_in, sum_out;

    logic         in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
    logic [0:0]   a1, b1, sum1;

    typedef struct {
        logic [W:0] res;
        int         acc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   last_acc = -1;
    bit   prev_ov = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum_out(sum_out), .cout(cout), .busy(busy)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clock(clock), .resetn(resetn), .in_valid(in_valid1), .in_ready(in_ready1),
        .a_in(a1), .b_in(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum_out(sum1), .cout(cout1), .busy(busy1)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: push on accepted operands, compare on output handshake.
    always @(negedge clock) begin
        if (!resetn) begin
            q.delete();
            prev_ov  = 1'b0;
            last_acc = -1;
        end else begin
            if (out_valid && !prev_ov) begin
                if (q.size() == 0) check("spurious_valid", 32'(out_valid), 32'd0);
                else check("latency", 32'(cyc - q[0].acc), 32'(W));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("pop_empty", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("sum", 32'(sum_out), 32'(e.res[W-1:0]));
                    check("cout", 32'(cout), 32'(e.res[W]));
                end
            end
            if (in_valid && in_ready) begin
                e.res = (W+1)'(a_in) + (W+1)'(b_in) + (W+1)'(cin);
                e.acc = cyc + 1;
                if (last_acc >= 0) check("spacing", 32'(e.acc - last_acc >= int'(W) + 2), 32'd1);
                last_acc = e.acc;
                q.push_back(e);
            end
            prev_ov = out_valid;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit hold);
        bit ok = 1'b0;
        a_in = a; b_in = b; cin = c; in_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clock);
            if (in_ready) ok = 1'b1;
        end
        tick();
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            if (q.size() == 0 && !out_valid) done = 1'b1;
            else tick();
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0; cin = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum_out), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_in_ready1", 32'(in_ready1), 32'd1);
        tick();

        // Basic add with per-cycle busy/out_valid profile.
        send(8'h5A, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i <= int'(W); i++) begin
            @(negedge clock);
            check("basic_busy", 32'(busy), 32'(i < int'(W)));
            check("basic_valid", 32'(out_valid), 32'(i == int'(W)));
        end
        check("basic_sum", 32'(sum_out), 32'h96);
        tick();
        wait_drain();

        // Backpressure: result held, inputs ignored.
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0, 1'b0);
        for (int n = 0; n < 40 && !out_valid; n++) @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            tick();
            in_valid = i[0];
            a_in = 8'($urandom);
            b_in = 8'($urandom);
            @(negedge clock);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(sum_out), 32'h46);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        @(negedge clock);
        check("bp_idle_ready", 32'(in_ready), 32'd1);
        check("bp_idle_valid", 32'(out_valid), 32'd0);
        tick();

        // Carry propagation.
        send(8'hFF, 8'h01, 1'b0, 1'b0); wait_drain();
        send(8'hFF, 8'hFF, 1'b1, 1'b0); wait_drain();
        send(8'h00, 8'h00, 1'b1, 1'b0); wait_drain();
        send(8'hF0, 8'h20, 1'b0, 1'b0); wait_drain();

        // Reset while the bit counter is 3.
        send(8'h11, 8'h22, 1'b0, 1'b0);
        repeat (3) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clock);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sum", 32'(sum_out), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        tick();
        send(8'h80, 8'h80, 1'b0, 1'b0); wait_drain();

        // Back-to-back random with in_valid and out_ready held high.
        out_ready = 1'b1;
        for (int i = 0; i < 1000; i++) send(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        in_valid = 1'b0;
        wait_drain();

        // WIDTH=1 corner against the full-adder truth table.
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            a1 = v[2:2]; b1 = v[1:1]; cin1 = v[0]; in_valid1 = 1'b1;
            @(negedge clock);
            check("w1_in_ready", 32'(in_ready1), 32'd1);
            tick();
            in_valid1 = 1'b0;
            @(negedge clock);
            check("w1_busy", 32'(busy1), 32'd1);
            check("w1_early_valid", 32'(out_valid1), 32'd0);
            @(negedge clock);
            check("w1_valid", 32'(out_valid1), 32'd1);
            check("w1_sum", 32'(sum1), 32'(v[2] ^ v[1] ^ v[0]));
            check("w1_cout", 32'(cout1), 32'((v[2] & v[1]) | (v[0] & (v[2] ^ v[1]))));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
